// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole controller covering spawning, mole lifetimes, hits and misses, score and lives.
// Optional MOLE_PENALTY_EN: a press on an unlit slot during play counts as a miss.
module mole_game_ctrl #(
    parameter int N_MOLES    = 10,
    parameter int MAX_ACTIVE = 3,
    parameter int LIVES      = 5,
    parameter int SPAWN_MS   = 500,
    parameter int LIFE_L0    = 1500,
    parameter int LIFE_L1    = 1000,
    parameter int LIFE_L2    = 750,
    parameter int LIFE_L3    = 500,
    parameter int SCORE_W    = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_ms_i,
    input  logic               start_i,
    input  logic [1:0]         level_i,
    input  logic [4:0]         rand_idx_i,
    input  logic [N_MOLES-1:0] btn_edge_i,
    output logic [N_MOLES-1:0] active_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [3:0]         lives_left_o,
    output logic [1:0]         game_state_o
);
    localparam int SP_W = $clog2(SPAWN_MS + 1);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_PLAY = 2'b01, S_OVER = 2'b10} state_t;

    state_t                    state_q, state_d;
    logic [N_MOLES-1:0]        active_q, active_d;
    logic [N_MOLES-1:0][15:0]  life_q, life_d;
    logic [SP_W-1:0]           spawn_q, spawn_d;
    logic [SCORE_W-1:0]        score_q, score_d;
    logic [3:0]                lives_q, lives_d;
    logic [1:0]                level_q, level_d;
    logic                      hit_q, hit_d, miss_q, miss_d;

    logic                      play, attempt, spawn_ok, miss_any;
    logic [N_MOLES-1:0]        hits, expire, penalty, sel;
    logic [5:0]                n_active, n_hits;
    logic [15:0]               life_init;
    logic [SCORE_W+5:0]        score_sum;

    // A hit on a slot masks its expiry in the same cycle.
    always_comb begin
        play = state_q == S_PLAY;
        hits = play ? btn_edge_i & active_q : '0;
`ifdef MOLE_PENALTY_EN
        penalty = play ? btn_edge_i & ~active_q : '0;
`else
        penalty = '0;
`endif
        n_active = '0;
        n_hits = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            expire[i] = play && tick_ms_i && active_q[i] && !hits[i] && life_q[i] == 16'd1;
            sel[i] = rand_idx_i == 5'(i);
            n_active = n_active + 6'(active_q[i]);
            n_hits = n_hits + 6'(hits[i]);
        end
        attempt = play && tick_ms_i && spawn_q == SP_W'(SPAWN_MS - 1);
        spawn_ok = attempt && |sel && !(|(sel & active_q)) && n_active < 6'(MAX_ACTIVE);
        miss_any = |expire || |penalty;
        life_init = level_q == 2'd0 ? 16'(LIFE_L0) :
                    level_q == 2'd1 ? 16'(LIFE_L1) :
                    level_q == 2'd2 ? 16'(LIFE_L2) : 16'(LIFE_L3);
        score_sum = (SCORE_W+6)'(score_q) + (SCORE_W+6)'(n_hits);
    end

    always_comb begin
        state_d = state_q;
        active_d = active_q;
        life_d = life_q;
        spawn_d = spawn_q;
        score_d = score_q;
        lives_d = lives_q;
        level_d = level_q;
        hit_d = 1'b0;
        miss_d = 1'b0;
        if (start_i) begin
            state_d = S_PLAY;
            active_d = '0;
            life_d = '0;
            spawn_d = '0;
            score_d = '0;
            lives_d = 4'(LIVES);
            level_d = level_i;
        end else if (play) begin
            for (int i = 0; i < N_MOLES; i++) begin
                if (hits[i] || expire[i]) begin
                    active_d[i] = 1'b0;
                    life_d[i] = '0;
                end else if (spawn_ok && sel[i]) begin
                    active_d[i] = 1'b1;
                    life_d[i] = life_init;
                end else if (active_q[i] && tick_ms_i) begin
                    life_d[i] = life_q[i] - 16'd1;
                end
            end
            if (tick_ms_i)
                spawn_d = attempt ? '0 : spawn_q + SP_W'(1);
            hit_d = |hits;
            miss_d = miss_any;
            score_d = |score_sum[SCORE_W+5:SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            // Several misses in one cycle still cost a single life.
            if (miss_any && lives_q != 4'd0)
                lives_d = lives_q - 4'd1;
            if (miss_any && lives_q <= 4'd1) begin
                state_d = S_OVER;
                active_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            active_q <= '0;
            life_q <= '0;
            spawn_q <= '0;
            score_q <= '0;
            lives_q <= 4'(LIVES);
            level_q <= '0;
            hit_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            state_q <= state_d;
            active_q <= active_d;
            life_q <= life_d;
            spawn_q <= spawn_d;
            score_q <= score_d;
            lives_q <= lives_d;
            level_q <= level_d;
            hit_q <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign active_o = active_q;
    assign hit_pulse_o = hit_q;
    assign miss_pulse_o = miss_q;
    assign score_o = score_q;
    assign lives_left_o = lives_q;
    assign game_state_o = state_q;
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: scoreboard bench for mole_game_ctrl with a game-level reference model.
// Timing parameters are scaled down so whole games and score saturation fit in a short run.
module tb_mole_game_ctrl;
    localparam int N = 10, MAXA = 3, LIVES = 5, SPAWN = 5, SW = 11;
    localparam int L0 = 40, L1 = 20, L2 = 15, L3 = 10;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0, rst_n = 1'b1, tick = 1'b0, start = 1'b0;
    logic [1:0] level = '0;
    logic [4:0] ridx = '0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] active;
    logic hit_p, miss_p;
    logic [SW-1:0] score;
    logic [3:0] lives;
    logic [1:0] gstate;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .N_MOLES(N), .MAX_ACTIVE(MAXA), .LIVES(LIVES), .SPAWN_MS(SPAWN),
        .LIFE_L0(L0), .LIFE_L1(L1), .LIFE_L2(L2), .LIFE_L3(L3), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_ms_i(tick), .start_i(start), .level_i(level),
        .rand_idx_i(ridx), .btn_edge_i(btn), .active_o(active), .hit_pulse_o(hit_p),
        .miss_pulse_o(miss_p), .score_o(score), .lives_left_o(lives), .game_state_o(gstate)
    );

    typedef struct packed {
        logic [N-1:0]  act;
        logic [SW-1:0] sc;
        logic [3:0]    lv;
        logic [1:0]    st;
        logic          h;
        logic          m;
    } obs_t;

    obs_t exp_q[$];
    int total = 0, bad = 0;

    // Game model: state 0 idle, 1 play, 2 over; remaining lifetime per lit mole in ms.
    int m_state, m_spawn, m_score, m_lives, m_level;
    int m_rem[N];
    bit m_lit[N];
    bit m_hit, m_miss;
    int lifes[4] = '{L0, L1, L2, L3};

    task automatic model_reset();
        m_state = 0; m_spawn = 0; m_score = 0; m_lives = LIVES; m_level = 0;
        m_hit = 0; m_miss = 0;
        for (int i = 0; i < N; i++) begin m_lit[i] = 0; m_rem[i] = 0; end
    endtask

    task automatic model_step(input bit s, input bit t, input int lv, input int ri, input logic [N-1:0] b);
        bit old[N];
        int nlit, nhit;
        bit any_miss, spawn;
        nlit = 0; nhit = 0; any_miss = 0; spawn = 0;
        m_hit = 0; m_miss = 0;
        if (s) begin
            m_state = 1; m_score = 0; m_lives = LIVES; m_spawn = 0; m_level = lv;
            for (int i = 0; i < N; i++) begin m_lit[i] = 0; m_rem[i] = 0; end
            return;
        end
        if (m_state != 1) return;
        old = m_lit;
        for (int i = 0; i < N; i++) nlit += int'(old[i]);
        if (t) begin
            m_spawn++;
            if (m_spawn == SPAWN) begin
                m_spawn = 0;
                if (ri < N) spawn = !old[ri] && nlit < MAXA;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (old[i]) begin
                if (b[i]) begin
                    nhit++;
                    m_lit[i] = 0;
                end else if (t) begin
                    m_rem[i] -= 1;
                    if (m_rem[i] == 0) begin m_lit[i] = 0; any_miss = 1; end
                end
            end
`ifdef MOLE_PENALTY_EN
            else if (b[i]) any_miss = 1;
`endif
        end
        if (spawn) begin m_lit[ri] = 1; m_rem[ri] = lifes[m_level]; end
        m_score += nhit;
        if (m_score > SMAX) m_score = SMAX;
        m_hit = nhit > 0;
        m_miss = any_miss;
        if (any_miss) begin
            if (m_lives > 0) m_lives--;
            if (m_lives == 0) begin
                m_state = 2;
                for (int i = 0; i < N; i++) m_lit[i] = 0;
            end
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < N; i++) o.act[i] = m_lit[i];
        o.sc = SW'(m_score); o.lv = 4'(m_lives); o.st = 2'(m_state); o.h = m_hit; o.m = m_miss;
        return o;
    endfunction

    task automatic cycle(input bit s, input bit t, input logic [1:0] lv, input logic [4:0] ri, input logic [N-1:0] b);
        @(negedge clk);
        start = s; tick = t; level = lv; ridx = ri; btn = b;
        model_step(s, t, int'(lv), int'(ri), b);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0; start = 1'b0; tick = 1'b0; btn = '0; ridx = '0; level = '0;
        #1;
        check("rst_state", int'(gstate), 0);
        check("rst_active", int'(active), 0);
        check("rst_score", int'(score), 0);
        check("rst_lives", int'(lives), LIVES);
        check("rst_pulses", int'({hit_p, miss_p}), 0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic sat_cycle();
        logic [N-1:0] b;
        int n;
        bit urgent;
        b = '0; n = 0; urgent = 0;
        for (int i = 0; i < N; i++)
            if (m_lit[i]) begin
                b[i] = 1'b1; n++;
                if (m_rem[i] <= 2) urgent = 1;
            end
        cycle(1'b0, 1'b1, 2'd0, 5'($urandom_range(0, N - 1)), (n == MAXA || urgent) ? b : '0);
    endtask

    initial forever begin
        obs_t e, g;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {active, score, lives, gstate, hit_p, miss_p};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL scoreboard t=%0t act=%h/%h score=%0d/%0d lives=%0d/%0d state=%0d/%0d hit=%b/%b miss=%b/%b (got/want)",
                         $time, g.act, e.act, g.sc, e.sc, g.lv, e.lv, g.st, e.st, g.h, e.h, g.m, e.m);
            end
        end
    end

    initial begin
        model_reset();
        do_reset();
        repeat (3) cycle(1'b0, 1'b1, 2'd0, 5'd3, '1);
        // Level 2 mole on slot 3 spawns, then expires with a single miss.
        cycle(1'b1, 1'b0, 2'd2, 5'd3, '0);
        repeat (SPAWN) cycle(1'b0, 1'b1, 2'd2, 5'd3, '0);
        check("spawn_slot3", int'(active), 8);
        repeat (L2 - 1) cycle(1'b0, 1'b1, 2'd2, 5'd3, '0);
        check("pre_expire_act", int'(active), 8);
        check("pre_expire_miss", int'(miss_p), 0);
        cycle(1'b0, 1'b1, 2'd2, 5'd3, '0);
        check("expire_act", int'(active), 0);
        check("expire_miss", int'(miss_p), 1);
        check("expire_lives", int'(lives), LIVES - 1);
        // Respawn, out-of-range index ignored, hit on the expiry tick wins.
        repeat (SPAWN) cycle(1'b0, 1'b1, 2'd2, 5'd3, '0);
        check("respawn_act", int'(active), 8);
        repeat (L2 - 1) cycle(1'b0, 1'b1, 2'd2, 5'd12, '0);
        check("idx12_nospawn", int'(active), 8);
        cycle(1'b0, 1'b1, 2'd2, 5'd12, 10'h008);
        check("hit_at_zero_hit", int'(hit_p), 1);
        check("hit_at_zero_miss", int'(miss_p), 0);
        check("hit_at_zero_score", int'(score), 1);
        check("hit_at_zero_lives", int'(lives), LIVES - 1);
        // Restart mid-play, then MAX_ACTIVE caps the fourth spawn.
        cycle(1'b1, 1'b0, 2'd0, 5'd0, '0);
        check("restart_score", int'(score), 0);
        check("restart_lives", int'(lives), LIVES);
        foreach (lifes[k]) begin
            logic [4:0] idx;
            idx = (k == 3) ? 5'd4 : 5'(k);
            repeat (SPAWN) cycle(1'b0, 1'b1, 2'd0, idx, '0);
        end
        check("max_active", int'(active), 7);
        repeat (LIVES) cycle(1'b0, 1'b0, 2'd0, 5'd0, 10'h200);
`ifdef MOLE_PENALTY_EN
        check("penalty_state", int'(gstate), 2);
        check("penalty_active", int'(active), 0);
        check("penalty_lives", int'(lives), 0);
        check("penalty_miss", int'(miss_p), 1);
`else
        check("nopenalty_state", int'(gstate), 1);
        check("nopenalty_active", int'(active), 7);
        check("nopenalty_lives", int'(lives), LIVES);
        check("nopenalty_miss", int'(miss_p), 0);
`endif
        repeat (4) cycle(1'b0, 1'b1, 2'd0, 5'd0, '1);
        // Asynchronous reset in the middle of a game.
        cycle(1'b1, 1'b0, 2'd1, 5'd5, '0);
        repeat (SPAWN) cycle(1'b0, 1'b1, 2'd1, 5'd5, '0);
        cycle(1'b0, 1'b0, 2'd1, 5'd5, 10'h020);
        check("pre_rst_score", int'(score), 1);
        do_reset();
        cycle(1'b0, 1'b1, 2'd0, 5'd0, '1);
        check("post_rst_idle", int'(gstate), 0);
        // Random play.
        for (int c = 0; c < 20000; c++) begin
            logic [N-1:0] b;
            bit s;
            for (int i = 0; i < N; i++)
                b[i] = m_lit[i] ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
            s = (m_state != 1) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4999) == 0);
            cycle(s, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 15)), b);
        end
        // Drive the score into saturation with multi-hit cycles.
        cycle(1'b1, 1'b0, 2'd0, 5'd0, '0);
        for (int c = 0; c < 30000 && m_score < SMAX; c++) sat_cycle();
        check("sat_reached", int'(score), SMAX);
        repeat (60) sat_cycle();
        check("sat_hold", int'(score), SMAX);
        check("sat_alive", int'(gstate), 1);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mole_game_ctrl.md
MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 N_MOLES, 10: number of mole slots (LEDs/buttons), 2..32.
REQ-002 MAX_ACTIVE, 3: maximum simultaneously lit moles, 1..N_MOLES.
REQ-003 LIVES, 5: lives loaded at game start, 1..15.
REQ-004 SPAWN_MS, 500: milliseconds between spawn attempts, >=1.
REQ-005 LIFE_L0/L1/L2/L3, 1500/1000/750/500: mole lifetime in ms per level, each >=1 and <2^16.
REQ-006 SCORE_W, 11: score width.
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 tick_ms  in  1  one-cycle strobe every 1 ms.
REQ-010 start  in  1  one-cycle pulse; starts or restarts a game.
REQ-011 level  in  2  difficulty; sampled only on accepted start.
REQ-012 rand_idx  in  5  random slot index for spawning.
REQ-013 btn_edge  in  N_MOLES  one-cycle press pulses, debounced.
REQ-014 active  out  N_MOLES  lit-mole one-hot-or-more vector, drives LEDs.
REQ-015 hit_pulse / miss_pulse  out  1  one-cycle event strobes.
REQ-016 score  out  SCORE_W  accumulated hits.
REQ-017 lives_left  out  4  remaining lives.
REQ-018 game_state  out  2  00 IDLE, 01 PLAY, 10 OVER.

Function
REQ-019 FSM: IDLE -start-> PLAY; PLAY -lives_left reaches 0-> OVER; OVER -start-> PLAY; start in PLAY restarts PLAY.
REQ-020 Accepted start: score=0, lives_left=LIVES, active=0, all slot counters=0, spawn counter=0, level latched; same cycle outputs update next edge.
REQ-021 Spawn counter advances on tick_ms in PLAY only; on reaching SPAWN_MS it clears and makes one spawn attempt.
REQ-022 Spawn succeeds iff rand_idx<N_MOLES, active[rand_idx]=0, popcount(active)<MAX_ACTIVE; else attempt dropped, no retry.
REQ-023 Spawned slot: active bit set and its lifetime counter loaded with latched-level LIFE value, visible cycle after attempt.
REQ-024 Each lit slot decrements on tick_ms; at 0 it clears and counts as an expiry miss.
REQ-025 Hit: btn_edge[i]&active[i]; clears slot i next cycle; hit has priority over expiry and spawn of the same slot in the same cycle.
REQ-026 score += popcount(hits) per cycle, saturating at 2^SCORE_W-1; hit_pulse=1 next cycle iff any hit.
REQ-027 Any miss in a cycle: miss_pulse=1 next cycle; lives_left decrements by exactly 1 per cycle regardless of miss count, floor 0.
REQ-028 Simultaneous hit and miss in one cycle: both pulses assert, both score and lives update.
REQ-029 In IDLE/OVER: active=0, btn_edge/tick_ms ignored, score and lives_left hold, no pulses.
REQ-030 Transition to OVER clears active the same edge lives_left becomes 0.

Reset
REQ-031 rst_n low: game_state=IDLE, active=0, score=0, lives_left=LIVES, pulses=0, all counters=0, latched level=0.
REQ-032 Reset asserted mid-game takes effect immediately (asynchronously); release requires a new start.

Configuration
REQ-033 MOLE_PENALTY_EN defined: btn_edge[i] with active[i]=0 in PLAY is a miss per REQ-027.
REQ-034 MOLE_PENALTY_EN undefined: presses on unlit slots are ignored; only expiries are misses.

Verification
REQ-035 Reset, start, level=2, rand_idx=3 held -> active=0x008 after 500 ms; expires at 1250 ms, miss_pulse once, lives_left=4.
REQ-036 Lit slot 3, btn_edge=0x008 in same cycle its counter hits 0 -> hit_pulse=1, miss_pulse=0, score=1, lives_left unchanged.
REQ-037 MAX_ACTIVE=3, three lit, fourth spawn attempt on free slot -> dropped, active popcount stays 3.
REQ-038 rand_idx=12 with N_MOLES=10 -> no spawn; rand_idx=5 on already-lit slot 5 -> no change, no counter reload.
REQ-039 MOLE_PENALTY_EN: btn_edge=0x001 on unlit slot, lives_left=1 -> miss_pulse, lives_left=0, game_state=OVER, active=0; without macro -> no change.
REQ-040 score at 2^SCORE_W-1, two hits same cycle -> score stays 2047, hit_pulse=1.
